ex_wb_arbiter: RTL and testbench

// - Parametrised writeback arbiter for the execute stage.
// - Merges NR_CH functional-unit result streams (ALU/branch, CSR, mult, FPU, ...) into one scoreboard write port.
// - Each channel has a DEPTH-entry FIFO, so a unit is never forced to stall just because another unit owns the port.
// - Output selection is round-robin; order is preserved within each channel.

---
 rtl/ex_wb_pkg.sv | 39 +++
 rtl/ex_wb_fifo.sv | 62 ++++++
 rtl/ex_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_ex_wb_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_wb_pkg.sv
// Shared types and helpers for the execute-stage writeback arbiter.
// Optional feature macro used by the top level: EX_WB_ARB_PERF_EN.
package ex_wb_pkg;

  // Widths of one writeback entry; the top-level DATA_W/TID_W must match these.
  localparam int WB_DATA_W = 64;
  localparam int WB_TID_W  = 3;

  // Default arbiter geometry.
  localparam int DEF_NR_CH = 4;
  localparam int DEF_DEPTH = 2;

  // Largest channel count the round-robin helper can scan.
  localparam int MAX_CH = 32;
  localparam int IDX_W  = $clog2(MAX_CH);

  typedef struct packed {
    logic [WB_DATA_W-1:0] result;
    logic [WB_TID_W-1:0]  trans_id;
    logic                 ex_valid;
  } wb_entry_t;

  // First set bit of mask at or above ptr, wrapping at nr_ch; 0 when mask is empty.
  // Scanning downward lets the closest candidate (smallest offset) win.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_CH-1:0] mask,
                                               input logic [IDX_W-1:0]  ptr,
                                               input logic [IDX_W:0]    nr_ch);
    logic [IDX_W:0]   idx;
    logic [IDX_W-1:0] pick;
    pick = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (idx >= nr_ch) idx = idx - nr_ch;
      if (((IDX_W + 1)'(i) < nr_ch) && mask[idx[IDX_W-1:0]]) pick = idx[IDX_W-1:0];
    end
    return pick;
  endfunction

endpackage

// File: rtl/ex_wb_fifo.sv
// Single-channel writeback FIFO. No fall-through: a full FIFO refuses a push
// even when it is popped in the same cycle. Flush empties it on the next edge.
module ex_wb_fifo
  import ex_wb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t wr_data,
  output wb_entry_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so any DEPTH works, not only powers of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ex_wb_arbiter.sv
// Execute-stage writeback arbiter: NR_CH per-unit FIFOs merged round-robin
// into a single scoreboard write port. The grant is locked while the port is
// stalled so the presented entry never changes before its handshake.
// Optional EX_WB_ARB_PERF_EN adds a saturating port-conflict counter.
module ex_wb_arbiter
  import ex_wb_pkg::*;
#(
  parameter int NR_CH  = DEF_NR_CH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int TID_W  = WB_TID_W,
  localparam int SRC_W = $clog2(NR_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [NR_CH-1:0]        ch_valid_i,
  output logic [NR_CH-1:0]        ch_ready_o,
  input  logic [NR_CH*DATA_W-1:0] ch_result_i,
  input  logic [NR_CH*TID_W-1:0]  ch_trans_id_i,
  input  logic [NR_CH-1:0]        ch_ex_valid_i,
`ifdef EX_WB_ARB_PERF_EN
  output logic [31:0]             conflict_cnt_o,
`endif
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [DATA_W-1:0]       wb_result_o,
  output logic [TID_W-1:0]        wb_trans_id_o,
  output logic                    wb_ex_valid_o,
  output logic [SRC_W-1:0]        wb_src_o
);

  wb_entry_t        heads [NR_CH];
  logic [NR_CH-1:0] full;
  logic [NR_CH-1:0] nonempty;
  logic [NR_CH-1:0] pop;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] pick;
  logic [SRC_W-1:0] grant;
  logic             lock_q;
  logic [SRC_W-1:0] lock_idx_q;
  logic             handshake;
  wb_entry_t        head_sel;

  for (genvar k = 0; k < NR_CH; k++) begin : g_ch
    wb_entry_t in_entry;
    logic      empty;

    assign in_entry.result   = ch_result_i[k*DATA_W +: DATA_W];
    assign in_entry.trans_id = ch_trans_id_i[k*TID_W +: TID_W];
    assign in_entry.ex_valid = ch_ex_valid_i[k];
    // Ready comes from registered occupancy only, never from wb_ready_i.
    assign ch_ready_o[k]     = !full[k] && !flush_i;
    assign nonempty[k]       = !empty;
    assign pop[k]            = handshake && (grant == SRC_W'(k));

    ex_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .flush   (flush_i),
      .push    (ch_valid_i[k]),
      .pop     (pop[k]),
      .wr_data (in_entry),
      .rd_data (heads[k]),
      .full    (full[k]),
      .empty   (empty)
    );
  end

  assign pick      = SRC_W'(rr_pick(MAX_CH'(nonempty), IDX_W'(rr_ptr), (IDX_W + 1)'(NR_CH)));
  assign grant     = lock_q ? lock_idx_q : pick;
  assign wb_valid_o = |nonempty;
  assign handshake = wb_valid_o && wb_ready_i;
  assign head_sel  = heads[grant];

  // Output mux; everything reads as zero while nothing is pending.
  always_comb begin
    wb_result_o   = '0;
    wb_trans_id_o = '0;
    wb_ex_valid_o = 1'b0;
    wb_src_o      = '0;
    if (wb_valid_o) begin
      wb_result_o   = head_sel.result;
      wb_trans_id_o = head_sel.trans_id;
      wb_ex_valid_o = head_sel.ex_valid;
      wb_src_o      = grant;
    end
  end

  // Round-robin pointer: moves just past the winner on each accepted entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= (grant == SRC_W'(NR_CH - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Grant lock: remember the presented channel while the port is stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (wb_valid_o && !wb_ready_i) begin
      lock_q     <= 1'b1;
      lock_idx_q <= grant;
    end else begin
      lock_q     <= 1'b0;
    end
  end

`ifdef EX_WB_ARB_PERF_EN
  logic [SRC_W:0] nr_busy;
  logic           conflict;

  // Number of channels currently holding at least one entry.
  always_comb begin
    nr_busy = '0;
    for (int k = 0; k < NR_CH; k++) nr_busy = nr_busy + (SRC_W + 1)'(nonempty[k]);
  end

  assign conflict = wb_valid_o && (!wb_ready_i || (nr_busy >= (SRC_W + 1)'(2)));

  // Saturating conflict counter; survives flushes, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_o <= '0;
    end else if (conflict && (conflict_cnt_o != 32'hFFFF_FFFF)) begin
      conflict_cnt_o <= conflict_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// Directed bench for ex_wb_arbiter (NR_CH=4, DEPTH=2): a vector table of
// per-cycle inputs and expected outputs, plus hand-written reset and
// EX_WB_ARB_PERF_EN sequences.
module tb_ex_wb_arbiter;

  localparam int NR_CH  = 4;
  localparam int DEPTH  = 2;
  localparam int DATA_W = 64;
  localparam int TID_W  = 3;

  typedef struct {
    logic [3:0]      ch_valid;
    logic [3:0][2:0] tids;
    logic            ready;
    logic            flush;
    logic            exp_valid;
    logic [1:0]      exp_src;
    logic [2:0]      exp_tid;
    logic [3:0]      exp_ready;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic [NR_CH-1:0]        ch_valid;
  logic [NR_CH-1:0]        ch_ready;
  logic [NR_CH*DATA_W-1:0] ch_result;
  logic [NR_CH*TID_W-1:0]  ch_trans_id;
  logic [NR_CH-1:0]        ch_ex_valid;
  logic                    wb_valid;
  logic                    wb_ready;
  logic [DATA_W-1:0]       wb_result;
  logic [TID_W-1:0]        wb_trans_id;
  logic                    wb_ex_valid;
  logic [1:0]              wb_src;
`ifdef EX_WB_ARB_PERF_EN
  logic [31:0]             conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  // clock / reset
  always #5 clk = ~clk;

  ex_wb_arbiter #(.NR_CH(NR_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .TID_W(TID_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .ch_valid_i    (ch_valid),
    .ch_ready_o    (ch_ready),
    .ch_result_i   (ch_result),
    .ch_trans_id_i (ch_trans_id),
    .ch_ex_valid_i (ch_ex_valid),
`ifdef EX_WB_ARB_PERF_EN
    .conflict_cnt_o(conflict_cnt),
`endif
    .wb_valid_o    (wb_valid),
    .wb_ready_i    (wb_ready),
    .wb_result_o   (wb_result),
    .wb_trans_id_o (wb_trans_id),
    .wb_ex_valid_o (wb_ex_valid),
    .wb_src_o      (wb_src)
  );

  // Result payload is a function of channel and tid so a mux error shows up.
  function automatic logic [63:0] res_of(input int k, input logic [2:0] t);
    return {32'hC0DE_0000 | 32'(k), 29'h0, t};
  endfunction

  function automatic logic [3:0][2:0] t4(input logic [2:0] t3, input logic [2:0] t2,
                                         input logic [2:0] t1, input logic [2:0] t0);
    return {t3, t2, t1, t0};
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0][2:0] t,
                              input logic rdy, input logic fl, input logic ev,
                              input logic [1:0] es, input logic [2:0] et,
                              input logic [3:0] er);
    vec_t r;
    r.ch_valid = v;   r.tids = t;      r.ready = rdy;   r.flush = fl;
    r.exp_valid = ev; r.exp_src = es;  r.exp_tid = et;  r.exp_ready = er;
    return r;
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver
  task automatic drive(input logic [3:0] v, input logic [3:0][2:0] t,
                       input logic rdy, input logic fl);
    ch_valid = v;
    for (int k = 0; k < NR_CH; k++) begin
      ch_trans_id[k*TID_W +: TID_W]   = t[k];
      ch_result[k*DATA_W +: DATA_W]   = res_of(k, t[k]);
      ch_ex_valid[k]                  = t[k][0];
    end
    wb_ready = rdy;
    flush    = fl;
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [1:0] es,
                               input logic [2:0] et, input logic [3:0] er);
    check({tag, " wb_valid"},    64'(wb_valid),    64'(ev));
    check({tag, " wb_src"},      64'(wb_src),      ev ? 64'(es) : 64'd0);
    check({tag, " wb_trans_id"}, 64'(wb_trans_id), ev ? 64'(et) : 64'd0);
    check({tag, " wb_result"},   wb_result,        ev ? res_of(int'(es), et) : 64'd0);
    check({tag, " wb_ex_valid"}, 64'(wb_ex_valid), ev ? 64'(et[0]) : 64'd0);
    check({tag, " ch_ready"},    64'(ch_ready),    64'(er));
  endtask

  initial begin
    // Round-robin: one entry per channel, drained in channel order.
    vecs.push_back(mk(4'hF, t4(3,2,1,0), 1, 0, 0, 0, 0, 4'hF)); // 0
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 1, 0, 0, 4'hF)); // 1
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 1, 1, 1, 4'hF)); // 2
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 1, 2, 2, 4'hF)); // 3
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 1, 3, 3, 4'hF)); // 4
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 0, 0, 0, 4'hF)); // 5
    // Backpressure lock: ch2 held while ch0 arrives from behind the pointer.
    vecs.push_back(mk(4'h4, t4(0,5,0,0), 0, 0, 0, 0, 0, 4'hF)); // 6
    vecs.push_back(mk(4'h1, t4(0,0,0,6), 0, 0, 1, 2, 5, 4'hF)); // 7
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 0, 0, 1, 2, 5, 4'hF)); // 8
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 0, 0, 1, 2, 5, 4'hF)); // 9
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 1, 2, 5, 4'hF)); // 10
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 1, 0, 6, 4'hF)); // 11
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 0, 0, 0, 4'hF)); // 12
    // Full FIFO on ch1: pop with a simultaneous push attempt, no fall-through.
    vecs.push_back(mk(4'h2, t4(0,0,1,0), 0, 0, 0, 0, 0, 4'hF)); // 13
    vecs.push_back(mk(4'h2, t4(0,0,2,0), 0, 0, 1, 1, 1, 4'hF)); // 14
    vecs.push_back(mk(4'h2, t4(0,0,3,0), 1, 0, 1, 1, 1, 4'hD)); // 15
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 0, 0, 1, 1, 2, 4'hF)); // 16
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 1, 1, 2, 4'hF)); // 17
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 0, 0, 0, 4'hF)); // 18
    // Flush: three entries in ch0/ch3 discarded, ch1 push dropped, pointer to 0.
    vecs.push_back(mk(4'h9, t4(2,0,0,1), 0, 0, 0, 0, 0, 4'hF)); // 19
    vecs.push_back(mk(4'h1, t4(0,0,0,3), 0, 0, 1, 3, 2, 4'hF)); // 20
    vecs.push_back(mk(4'h2, t4(0,0,7,0), 0, 1, 1, 3, 2, 4'h0)); // 21
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 0, 0, 0, 4'hF)); // 22
    vecs.push_back(mk(4'hA, t4(5,0,4,0), 1, 0, 0, 0, 0, 4'hF)); // 23
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 1, 1, 4, 4'hF)); // 24
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 1, 3, 5, 4'hF)); // 25
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 0, 0, 0, 4'hF)); // 26
    // Handshake in the flush cycle still presents the head.
    vecs.push_back(mk(4'h1, t4(0,0,0,1), 0, 0, 0, 0, 0, 4'hF)); // 27
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 1, 1, 0, 1, 4'h0)); // 28
    vecs.push_back(mk(4'h0, t4(0,0,0,0), 1, 0, 0, 0, 0, 4'hF)); // 29

    // Reset held two cycles with all channels offering data.
    rst = 1'b1;
    drive(4'hF, t4(1,2,3,4), 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'h0, t4(0,0,0,0), 1'b0, 1'b0);
    #1;
    check_outputs("reset", 1'b0, 2'd0, 3'd0, 4'hF);

    // Table: drive, let combinational outputs settle, compare, then clock.
    foreach (vecs[i]) begin
      drive(vecs[i].ch_valid, vecs[i].tids, vecs[i].ready, vecs[i].flush);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_src,
                    vecs[i].exp_tid, vecs[i].exp_ready);
      @(posedge clk);
      #1;
    end

`ifdef EX_WB_ARB_PERF_EN
    // Conflict counter: reset to zero, one conflict cycle, unaffected by flush.
    rst = 1'b1;
    drive(4'h0, t4(0,0,0,0), 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("perf reset", 64'(conflict_cnt), 64'd0);
    drive(4'h3, t4(0,0,1,2), 1'b1, 1'b0);  // push ch0, ch1
    @(posedge clk); #1;
    drive(4'h0, t4(0,0,0,0), 1'b1, 1'b0);  // two busy: counts
    @(posedge clk); #1;
    @(posedge clk); #1;                    // one busy, ready: no count
    drive(4'h0, t4(0,0,0,0), 1'b0, 1'b0);
    #1;
    check("perf two_busy", 64'(conflict_cnt), 64'd1);
    drive(4'h4, t4(0,3,0,0), 1'b1, 1'b0);  // push ch2
    @(posedge clk); #1;
    drive(4'h0, t4(0,0,0,0), 1'b1, 1'b1);  // flush with handshake, one busy
    @(posedge clk); #1;
    drive(4'h0, t4(0,0,0,0), 1'b0, 1'b0);
    @(posedge clk); #1;
    check("perf after_flush", 64'(conflict_cnt), 64'd1);
`endif

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
